// File: rtl/dmem_access_ctrl_if.sv
// Bundle of MEM-stage request, data-cache bus and writeback-side signals
// for dmem_access_ctrl. The master modport is the controller's view; the
// slave modport is the view of whoever drives requests and answers the cache.
interface dmem_access_ctrl_if;
    // Request from EX/MEM
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // Data-cache bus
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mbe;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    // Pipeline control and load result
    logic        stall;
    logic        done;
    logic        access_fault;
    logic [31:0] ld_word;
    logic [1:0]  ld_offset;

    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  dmem_resp, dmem_rdata,
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
        output stall, done, access_fault, ld_word, ld_offset
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output dmem_resp, dmem_rdata,
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
        input  stall, done, access_fault, ld_word, ld_offset
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory requester: turns a load/store into a registered
// cache request, stalls the pipeline until the cache responds, and returns
// the raw read word plus byte offset for writeback extraction.
module dmem_access_ctrl (
    input logic                clk,
    input logic                rst_n,
    dmem_access_ctrl_if.master bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      r_state;
    logic        r_read;
    logic        r_write;
    logic [31:0] r_address;
    logic [31:0] r_wdata;
    logic [3:0]  r_mbe;
    logic        r_done;
    logic        r_fault;
    logic [31:0] r_ld_word;
    logic [1:0]  r_ld_offset;
    // Offset of the in-flight access; published to ld_offset only when a load completes
    logic [1:0]  r_pend_off;

    logic [1:0]  w_off;
    logic        w_legal;
    logic [3:0]  w_mbe;
    logic [31:0] w_wdata;

    assign w_off   = bus.req_addr[1:0];
    assign w_wdata = bus.req_wdata << {w_off, 3'b000};

    // Decode legality and store byte lanes from funct3 and the address offset
    always_comb begin
        w_legal = 1'b0;
        w_mbe   = 4'b0000;
        unique case (bus.req_funct3)
            3'b000: begin
                w_legal = 1'b1;
                w_mbe   = 4'b0001 << w_off;
            end
            3'b001: begin
                w_legal = ~w_off[0];
                w_mbe   = 4'b0011 << w_off;
            end
            3'b010: begin
                w_legal = (w_off == 2'b00);
                w_mbe   = 4'b1111;
            end
            3'b100:  w_legal = ~bus.req_write;
            3'b101:  w_legal = ~bus.req_write & ~w_off[0];
            default: w_legal = 1'b0;
        endcase
        if (!bus.req_write) begin
            w_mbe = 4'b0000;
        end
    end

    // Access FSM with all bus and result outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_address   <= 32'h0;
            r_wdata     <= 32'h0;
            r_mbe       <= 4'b0000;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_ld_word   <= 32'h0;
            r_ld_offset <= 2'b00;
            r_pend_off  <= 2'b00;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.req_valid) begin
                        if (w_legal) begin
                            r_address  <= {bus.req_addr[31:2], 2'b00};
                            r_wdata    <= w_wdata;
                            r_mbe      <= w_mbe;
                            r_pend_off <= w_off;
                            r_read     <= ~bus.req_write;
                            r_write    <= bus.req_write;
                            r_state    <= StBusy;
                        end else begin
                            r_done  <= 1'b1;
                            r_fault <= 1'b1;
                            r_state <= StDone;
                        end
                    end
                end
                StBusy: begin
                    if (bus.dmem_resp) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        if (r_read) begin
                            r_ld_word   <= bus.dmem_rdata;
                            r_ld_offset <= r_pend_off;
                        end
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    // Same instruction is still presented here, so req_valid is ignored
                    r_done  <= 1'b0;
                    r_fault <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.dmem_read    = r_read;
    assign bus.dmem_write   = r_write;
    assign bus.dmem_address = r_address;
    assign bus.dmem_wdata   = r_wdata;
    assign bus.dmem_mbe     = r_mbe;
    assign bus.done         = r_done;
    assign bus.access_fault = r_fault;
    assign bus.ld_word      = r_ld_word;
    assign bus.ld_offset    = r_ld_offset;
    // Reset gating keeps stall low even if req_valid is held during reset
    assign bus.stall = rst_n & (((r_state == StIdle) & bus.req_valid) | (r_state == StBusy));

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: expected completion results are
// queued as each access is driven and compared when done pulses.
module tb_dmem_access_ctrl;

    logic clk;
    logic rst_n;

    dmem_access_ctrl_if u_if ();

    dmem_access_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        fault;
        logic        chk_off;
        logic [31:0] word;
        logic [1:0]  off;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests;
    int          n_fail;
    logic [31:0] m_word;
    logic [1:0]  m_off;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one access starting at a negedge; resp is pulsed in cycle k (req seen in cycle 0)
    task automatic do_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata, input int k);
        exp_t        e;
        exp_t        got_e;
        logic        legal;
        logic [1:0]  off;
        logic [3:0]  mbe;
        logic [31:0] wd;
        int          stall_cnt;
        int          busy_cnt;
        int          done_cyc;
        bit          got_done;
        off = addr[1:0];
        case (f3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = !off[0];
            3'b010:  legal = (off == 2'b00);
            3'b100:  legal = !wr;
            3'b101:  legal = !wr && !off[0];
            default: legal = 1'b0;
        endcase
        if (!wr)               mbe = 4'b0000;
        else if (f3 == 3'b000) mbe = 4'b0001 << off;
        else if (f3 == 3'b001) mbe = 4'b0011 << off;
        else                   mbe = 4'b1111;
        wd = wdata << {off, 3'b000};
        if (legal && !wr) begin
            m_word = rdata;
            m_off  = off;
        end
        e.fault   = !legal;
        e.chk_off = !wr;
        e.word    = m_word;
        e.off     = m_off;
        sb_q.push_back(e);

        u_if.req_valid  = 1'b1;
        u_if.req_write  = wr;
        u_if.req_funct3 = f3;
        u_if.req_addr   = addr;
        u_if.req_wdata  = wdata;
        stall_cnt = 0;
        busy_cnt  = 0;
        done_cyc  = -1;
        got_done  = 1'b0;
        for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
            u_if.dmem_resp  = (cyc == k);
            u_if.dmem_rdata = (cyc == k) ? rdata : 32'h5A5A_0F0F;
            #1;
            if (u_if.stall) stall_cnt++;
            if (u_if.dmem_read || u_if.dmem_write) begin
                busy_cnt++;
                check_eq("dmem_read", 32'(u_if.dmem_read), 32'(!wr));
                check_eq("dmem_write", 32'(u_if.dmem_write), 32'(wr));
                check_eq("dmem_address", u_if.dmem_address, {addr[31:2], 2'b00});
                check_eq("dmem_mbe", 32'(u_if.dmem_mbe), 32'(mbe));
                if (wr) check_eq("dmem_wdata", u_if.dmem_wdata, wd);
            end
            if (u_if.done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                if (sb_q.size() == 0) begin
                    check_eq("sb_empty", 32'd1, 32'd0);
                end else begin
                    got_e = sb_q.pop_front();
                    check_eq("access_fault", 32'(u_if.access_fault), 32'(got_e.fault));
                    check_eq("ld_word", u_if.ld_word, got_e.word);
                    if (got_e.chk_off) check_eq("ld_offset", 32'(u_if.ld_offset), 32'(got_e.off));
                end
            end
            @(negedge clk);
        end
        u_if.dmem_resp = 1'b0;
        u_if.req_valid = 1'b0;
        if (!got_done) check_eq("done_timeout", 32'd0, 32'd1);
        check_eq("done_cycle", done_cyc, legal ? k + 1 : 1);
        check_eq("busy_cycles", busy_cnt, legal ? k : 0);
        check_eq("stall_cycles", stall_cnt, legal ? k + 1 : 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_read"}, 32'(u_if.dmem_read), 32'd0);
        check_eq({tag, "_write"}, 32'(u_if.dmem_write), 32'd0);
        check_eq({tag, "_addr"}, u_if.dmem_address, 32'd0);
        check_eq({tag, "_wdata"}, u_if.dmem_wdata, 32'd0);
        check_eq({tag, "_mbe"}, 32'(u_if.dmem_mbe), 32'd0);
        check_eq({tag, "_done"}, 32'(u_if.done), 32'd0);
        check_eq({tag, "_fault"}, 32'(u_if.access_fault), 32'd0);
        check_eq({tag, "_ld_word"}, u_if.ld_word, 32'd0);
        check_eq({tag, "_ld_off"}, 32'(u_if.ld_offset), 32'd0);
        check_eq({tag, "_stall"}, 32'(u_if.stall), 32'd0);
    endtask

    initial begin
        logic [2:0] f3_tab [6];
        n_tests = 0;
        n_fail  = 0;
        m_word  = 32'h0;
        m_off   = 2'b00;
        f3_tab  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
        rst_n            = 1'b0;
        u_if.req_valid   = 1'b0;
        u_if.req_write   = 1'b0;
        u_if.req_funct3  = 3'b000;
        u_if.req_addr    = 32'h0;
        u_if.req_wdata   = 32'h0;
        u_if.dmem_resp   = 1'b0;
        u_if.dmem_rdata  = 32'h0;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_idle_outputs("post_reset");
        @(negedge clk);

        // Directed cases
        do_access(1'b0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 3);
        do_access(1'b1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 32'h0, 2);
        do_access(1'b1, 3'b001, 32'h0000_2002, 32'h0000_1234, 32'h0, 1);
        do_access(1'b0, 3'b001, 32'h0000_3001, 32'h0, 32'h1111_1111, 99);
        do_access(1'b1, 3'b010, 32'h0000_3002, 32'hCAFE_F00D, 32'h0, 99);
        do_access(1'b1, 3'b100, 32'h0000_3000, 32'h0000_0077, 32'h0, 99);
        do_access(1'b0, 3'b011, 32'h0000_3000, 32'h0, 32'h2222_2222, 99);
        do_access(1'b0, 3'b100, 32'h0000_4002, 32'h0, 32'h0BAD_CAFE, 1);
        do_access(1'b0, 3'b010, 32'h0000_4008, 32'h0, 32'h1357_9BDF, 1);

        // Reset during BUSY with req_valid still held, then a stray resp
        u_if.req_valid  = 1'b1;
        u_if.req_write  = 1'b0;
        u_if.req_funct3 = 3'b010;
        u_if.req_addr   = 32'h0000_5000;
        @(negedge clk);
        #1;
        check_eq("rst_busy_read", 32'(u_if.dmem_read), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        m_word = 32'h0;
        m_off  = 2'b00;
        @(negedge clk);
        rst_n          = 1'b1;
        u_if.req_valid = 1'b0;
        u_if.dmem_resp = 1'b1;
        u_if.dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        u_if.dmem_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_idle_outputs("after_reset");
            @(negedge clk);
        end

        // Store then load: store leaves ld_word alone
        do_access(1'b1, 3'b010, 32'h0000_6000, 32'h8765_4321, 32'h0, 2);
        do_access(1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'h8765_4321, 2);

        // Randomized mix, including illegal encodings
        for (int i = 0; i < 12; i++) begin
            do_access(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 5)], $urandom,
                      $urandom, $urandom, $urandom_range(1, 4));
        end

        check_eq("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
